// File: rtl/reg_bank_pkg.sv
// Shared definitions for the sparse integer register write bank (x0, x9, x18..x27).
package reg_bank_pkg;

    localparam int NUM_REGS   = 12;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Architectural index of each physical slot; slot 0 is the hardwired-zero x0.
    localparam logic [7:0] MAPPED_IDX [NUM_REGS] = '{
        8'd0,  8'd9,  8'd18, 8'd19, 8'd20, 8'd21,
        8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27
    };

    function automatic logic is_mapped(input logic [31:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == {24'd0, MAPPED_IDX[i]}) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/reg_wr_decode.sv
// Combinational decode of a register index into a one-hot slot select and a mapped flag.
module reg_wr_decode
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] sel,
    output logic                hit
);

    // One-hot slot select and mapped flag for the incoming index
    always_comb begin
        sel = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(addr) == {24'd0, MAPPED_IDX[i]}) begin
                sel[i] = 1'b1;
            end else begin
                sel[i] = 1'b0;
            end
        end
        hit = is_mapped(32'(addr));
    end

endmodule

// File: rtl/reg_write_bank.sv
// Write side of the sparse register set: one-entry staging buffer feeding twelve registers.
// Optional build macro WB_BYPASS_EN forwards staged data onto the matching q output.
module reg_write_bank
    import reg_bank_pkg::*;
#(
    parameter int               DATA_W    = DATA_W_DEF,
    parameter int               ADDR_W    = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit_stall,
    output logic              wr_err,
    output logic [DATA_W-1:0] q0,
    output logic [DATA_W-1:0] q9,
    output logic [DATA_W-1:0] q18,
    output logic [DATA_W-1:0] q19,
    output logic [DATA_W-1:0] q20,
    output logic [DATA_W-1:0] q21,
    output logic [DATA_W-1:0] q22,
    output logic [DATA_W-1:0] q23,
    output logic [DATA_W-1:0] q24,
    output logic [DATA_W-1:0] q25,
    output logic [DATA_W-1:0] q26,
    output logic [DATA_W-1:0] q27
);

    logic                stage_valid_r;
    logic [ADDR_W-1:0]   stage_addr_r;
    logic [DATA_W-1:0]   stage_data_r;
    logic                wr_err_r;
    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [DATA_W-1:0]   view_s [NUM_REGS];
    logic [NUM_REGS-1:0] stage_sel_s;
    logic                stage_hit_s;
    logic                accept_s;
    logic                commit_s;

    reg_wr_decode #(.ADDR_W(ADDR_W)) u_decode (
        .addr (stage_addr_r),
        .sel  (stage_sel_s),
        .hit  (stage_hit_s)
    );

    // A full stage can still take a new request when it retires on the same edge
    assign wr_ready = !stage_valid_r || !commit_stall;
    assign accept_s = wr_valid && wr_ready;
    assign commit_s = stage_valid_r && !commit_stall;

    // Staging buffer and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_r <= 1'b0;
            stage_addr_r  <= {ADDR_W{1'b0}};
            stage_data_r  <= {DATA_W{1'b0}};
            wr_err_r      <= 1'b0;
        end else begin
            wr_err_r <= commit_s && !stage_hit_s;
            if (accept_s) begin
                stage_valid_r <= 1'b1;
                stage_addr_r  <= wr_addr;
                stage_data_r  <= wr_data;
            end else if (commit_s) begin
                stage_valid_r <= 1'b0;
            end
        end
    end

    // Register array; slot 0 (x0) only ever holds zero
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_r[0] <= {DATA_W{1'b0}};
            for (int k = 1; k < NUM_REGS; k++) begin
                regs_r[k] <= RESET_VAL;
            end
        end else if (commit_s) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (stage_sel_s[k]) begin
                    regs_r[k] <= (k == 0) ? {DATA_W{1'b0}} : stage_data_r;
                end
            end
        end
    end

    // Output view: committed contents, optionally overlaid with the pending write
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
`ifdef WB_BYPASS_EN
            if (stage_valid_r && stage_hit_s && stage_sel_s[k] && (k != 0)) begin
                view_s[k] = stage_data_r;
            end else begin
                view_s[k] = regs_r[k];
            end
`else
            view_s[k] = regs_r[k];
`endif
        end
    end

    assign wr_err = wr_err_r;
    assign q0  = view_s[0];
    assign q9  = view_s[1];
    assign q18 = view_s[2];
    assign q19 = view_s[3];
    assign q20 = view_s[4];
    assign q21 = view_s[5];
    assign q22 = view_s[6];
    assign q23 = view_s[7];
    assign q24 = view_s[8];
    assign q25 = view_s[9];
    assign q26 = view_s[10];
    assign q27 = view_s[11];

endmodule

// File: tb/tb_reg_write_bank.sv
// Self-checking bench for reg_write_bank: vector table plus scoreboard of pending writes.
module tb_reg_write_bank;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        commit_stall;
    logic        wr_err;
    logic [31:0] q0, q9, q18, q19, q20, q21, q22, q23, q24, q25, q26, q27;
    logic [31:0] q_act [12];

    always #5 clk = ~clk;

    reg_write_bank #(.DATA_W(32), .ADDR_W(5), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit_stall(commit_stall),
        .wr_err(wr_err),
        .q0(q0), .q9(q9), .q18(q18), .q19(q19), .q20(q20), .q21(q21),
        .q22(q22), .q23(q23), .q24(q24), .q25(q25), .q26(q26), .q27(q27)
    );

    always_comb begin
        q_act[0]  = q0;  q_act[1]  = q9;  q_act[2]  = q18; q_act[3]  = q19;
        q_act[4]  = q20; q_act[5]  = q21; q_act[6]  = q22; q_act[7]  = q23;
        q_act[8]  = q24; q_act[9]  = q25; q_act[10] = q26; q_act[11] = q27;
    end

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic        s;
        logic        exp_ready;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t        vecs [23];
    wr_t         sb [$];
    logic [31:0] exp_q [12];
    logic        exp_err;
    int          checks   = 0;
    int          failures = 0;

    function automatic int slot(input logic [4:0] a);
        if (a == 5'd0) return 0;
        if (a == 5'd9) return 1;
        if (a >= 5'd18 && a <= 5'd27) return int'(a) - 16;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] view;
        check("wr_err", {31'd0, wr_err}, {31'd0, exp_err});
        for (int k = 0; k < 12; k++) begin
            view = exp_q[k];
`ifdef WB_BYPASS_EN
            if (sb.size() > 0 && k != 0 && slot(sb[0].a) == k) view = sb[0].d;
`endif
            check($sformatf("q_slot%0d", k), q_act[k], view);
        end
    endtask

    // One clock: drive at negedge, check ready, update model at posedge, check outputs
    task automatic step(input logic r, input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic s, input logic chk_rdy, input logic exp_rdy);
        wr_t e;
        logic acc;
        logic com;
        int   sl;
        @(negedge clk);
        rst = r; wr_valid = v; wr_addr = a; wr_data = d; commit_stall = s;
        #1;
        if (chk_rdy) check("wr_ready", {31'd0, wr_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        if (r) begin
            sb.delete();
            exp_err = 1'b0;
            exp_q[0] = 32'd0;
            for (int k = 1; k < 12; k++) exp_q[k] = RV;
        end else begin
            com = (sb.size() > 0) && !s;
            acc = v && ((sb.size() == 0) || !s);
            exp_err = 1'b0;
            if (com) begin
                e  = sb.pop_front();
                sl = slot(e.a);
                if (sl < 0) exp_err = 1'b1;
                else if (sl > 0) exp_q[sl] = e.d;
            end
            if (acc) begin
                e.a = a; e.d = d;
                sb.push_back(e);
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd9,  32'hDEADBEEF, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 5'd18, 32'd1,        1'b0, 1'b1};
        vecs[2]  = '{1'b1, 5'd19, 32'd2,        1'b0, 1'b1};
        vecs[3]  = '{1'b1, 5'd27, 32'd3,        1'b0, 1'b1};
        vecs[4]  = '{1'b1, 5'd20, 32'd5,        1'b0, 1'b1};
        vecs[5]  = '{1'b1, 5'd22, 32'd6,        1'b1, 1'b0};
        vecs[6]  = '{1'b1, 5'd22, 32'd6,        1'b1, 1'b0};
        vecs[7]  = '{1'b1, 5'd22, 32'd6,        1'b1, 1'b0};
        vecs[8]  = '{1'b1, 5'd22, 32'd6,        1'b0, 1'b1};
        vecs[9]  = '{1'b1, 5'd0,  32'd7,        1'b0, 1'b1};
        vecs[10] = '{1'b1, 5'd5,  32'hAA,       1'b0, 1'b1};
        vecs[11] = '{1'b0, 5'd0,  32'd0,        1'b0, 1'b1};
        vecs[12] = '{1'b0, 5'd0,  32'd0,        1'b0, 1'b1};
        vecs[13] = '{1'b1, 5'd31, 32'd1,        1'b0, 1'b1};
        vecs[14] = '{1'b1, 5'd9,  32'h11,       1'b0, 1'b1};
        vecs[15] = '{1'b1, 5'd9,  32'h22,       1'b0, 1'b1};
        vecs[16] = '{1'b0, 5'd0,  32'd0,        1'b0, 1'b1};
        vecs[17] = '{1'b0, 5'd0,  32'd0,        1'b0, 1'b1};
        vecs[18] = '{1'b1, 5'd17, 32'h17,       1'b0, 1'b1};
        vecs[19] = '{1'b1, 5'd28, 32'h28,       1'b0, 1'b1};
        vecs[20] = '{1'b1, 5'd1,  32'h01,       1'b0, 1'b1};
        vecs[21] = '{1'b0, 5'd0,  32'd0,        1'b0, 1'b1};
        vecs[22] = '{1'b0, 5'd0,  32'd0,        1'b0, 1'b1};

        rst = 1'b1; wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; commit_stall = 1'b0;
        exp_err = 1'b0;
        for (int k = 0; k < 12; k++) exp_q[k] = 32'd0;

        // Reset held two cycles; a request during reset must be ignored
        step(1'b1, 1'b1, 5'd9, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd9, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
        check("reset_ready", {31'd0, wr_ready}, 32'd1);

        for (int i = 0; i < 23; i++) begin
            step(1'b0, vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].s, 1'b1, vecs[i].exp_ready);
        end

        // Reset while a write to x21 sits stalled in the stage: it must never land
        step(1'b0, 1'b1, 5'd21, 32'd9, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd0,  32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 5'd0,  32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 5'd0,  32'd0, 1'b1, 1'b1, 1'b0);
        check("ready_after_rst", {31'd0, wr_ready}, 32'd1);
        step(1'b0, 1'b0, 5'd0,  32'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd0,  32'd0, 1'b0, 1'b1, 1'b1);
        check("q21_discarded", q21, RV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
